// File: rtl/stream_mux_rr_pkg.sv
// Shared write-back definitions for the stream multiplexer and its arbiter.
package stream_mux_rr_pkg;

  // Default data width of a write-back channel.
  localparam int DATA_W = 32;

  // Write-back source channel indices as wired at the shared write-back port.
  localparam int WB_ALU  = 0;
  localparam int WB_MEM  = 1;
  localparam int WB_CP0  = 2;
  localparam int WB_LINK = 3;

  // Advance a channel index by one, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational channel arbiter: round-robin search from a pointer, or a
// forced channel that only wins when it actually has a word.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] in_valid,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              force_en,
  input  logic [SEL_W-1:0]  force_sel,
  output logic              grant_valid,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] cur;

  // Pick the granted channel: forced index if valid, else first valid at or after ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cur         = ptr;
    if (force_en) begin
      if (int'(force_sel) < NUM_IN) begin
        if (in_valid[force_sel]) begin
          grant_valid = 1'b1;
          grant_idx   = force_sel;
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!grant_valid && in_valid[cur]) begin
          grant_valid = 1'b1;
          grant_idx   = cur;
        end
        cur = SEL_W'(wrap_inc(int'(cur), NUM_IN));
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with valid/ready handshakes, round-robin or
// forced selection, and a registered output stage feeding shared write-back.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  // The output register may take a new word when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arbiter (
    .in_valid    (in_valid),
    .ptr         (ptr),
    .force_en    (force_en),
    .force_sel   (force_sel),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Acknowledge only the granted channel, and only when the word can be stored.
  always_comb begin
    in_ready = '0;
    if (!rst && grant_valid && load) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Route the granted channel's word toward the output register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load a granted word, drain when nothing is granted, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer moves past the winner only on round-robin accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid && load && !force_en) begin
      ptr <= SEL_W'(wrap_inc(int'(grant_idx), NUM_IN));
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, reset checks,
// and a randomized run against a behavioural model with an in-order scoreboard.
module tb_stream_mux_rr;

  localparam int NUM_IN = 4;
  localparam int WIDTH  = 32;
  localparam logic [31:0] BASE = 32'hA000_0000;

  logic                    clk;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    force_en;
  logic [1:0]              force_sel;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_sel;
  logic                    out_valid;
  logic                    out_ready;

  int n_vec;
  int n_err;
  int seq [NUM_IN];

  // Behavioural model state
  logic        m_valid;
  logic [1:0]  m_sel;
  int          m_ptr;
  logic [31:0] sbq [$];
  int          sbch [$];

  typedef struct {
    logic [3:0] v;
    logic       fe;
    logic [1:0] fs;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t tbl [22];

  stream_mux_rr #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word that channel ch presents: base + ch*16 + its sequence number.
  function automatic logic [31:0] chanWord(input int ch, input int s);
    return BASE + 32'(ch * 16) + 32'(s);
  endfunction

  // Reference arbitration: forced channel if valid, else scan from ptr in ring order; -1 = none.
  function automatic int modelGrant(input logic [3:0] v, input logic fe,
                                    input logic [1:0] fs, input int ptr);
    if (fe) begin
      if (int'(fs) < NUM_IN && v[fs]) return int'(fs);
      return -1;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (v[(ptr + k) % NUM_IN]) return (ptr + k) % NUM_IN;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [3:0] v, input logic fe,
                               input logic [1:0] fs, input logic ordy);
    in_valid  = v;
    force_en  = fe;
    force_sel = fs;
    out_ready = ordy;
    for (int i = 0; i < NUM_IN; i++) begin
      in_data[i*WIDTH +: WIDTH] = chanWord(i, seq[i]);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One randomized cycle checked against the model and scoreboard.
  task automatic randomStep(input logic [3:0] v, input logic fe,
                            input logic [1:0] fs, input logic ordy);
    int          g;
    logic        ld;
    logic [3:0]  er;
    logic [31:0] w;
    int          ch;
    @(negedge clk);
    applyStimulus(v, fe, fs, ordy);
    #1;
    g  = modelGrant(v, fe, fs, m_ptr);
    ld = !m_valid || ordy;
    er = (g >= 0 && ld) ? 4'(1 << g) : 4'b0000;
    checkOutput("rand_in_ready", 32'(in_ready), 32'(er));
    if (m_valid && ordy) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL sb_underflow: got output transfer, expected none pending");
      end else begin
        w  = sbq.pop_front();
        ch = sbch.pop_front();
        checkOutput("sb_data", out_data, w);
        checkOutput("sb_chan", 32'(out_sel), 32'(ch));
      end
    end
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        sbq.push_back(chanWord(g, seq[g]));
        sbch.push_back(g);
        seq[g]++;
        m_valid = 1'b1;
        m_sel   = 2'(g);
        if (!fe) m_ptr = (g + 1) % NUM_IN;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    checkOutput("rand_out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("rand_out_sel", 32'(out_sel), 32'(m_sel));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < NUM_IN; i++) seq[i] = 0;

    //            v        fe    fs     ordy  ready    valid sel
    tbl[0]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[2]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[3]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[4]  = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[6]  = '{4'b0101, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{4'b0101, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[8]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[9]  = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[10] = '{4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[11] = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[12] = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[13] = '{4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[14] = '{4'b1011, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[15] = '{4'b1011, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd2};
    tbl[16] = '{4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[17] = '{4'b0111, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[18] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[19] = '{4'b0010, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 2'd1};
    tbl[20] = '{4'b0010, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[21] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd1};

    // Power-on reset with requests pending: nothing acknowledged, outputs cleared.
    rst = 1'b1;
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b1);
    #3;
    checkOutput("por_out_valid", 32'(out_valid), 32'd0);
    checkOutput("por_out_data", out_data, 32'd0);
    checkOutput("por_out_sel", 32'(out_sel), 32'd0);
    checkOutput("por_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1);
    rst = 1'b0;

    // Directed vectors: fairness, wrap/skip, backpressure, forced mode, drain.
    for (int r = 0; r < 22; r++) begin
      @(negedge clk);
      applyStimulus(tbl[r].v, tbl[r].fe, tbl[r].fs, tbl[r].ordy);
      #1;
      checkOutput($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].exp_ready));
      @(posedge clk);
      #1;
      checkOutput($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_valid));
      checkOutput($sformatf("tbl%0d_out_sel", r), 32'(out_sel), 32'(tbl[r].exp_sel));
      checkOutput($sformatf("tbl%0d_out_data", r), out_data, chanWord(int'(tbl[r].exp_sel), 0));
    end

    // Reset mid-run with a word held in the output register.
    @(negedge clk);
    applyStimulus(4'b1111, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("mid_pre_sel", 32'(out_sel), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_data", out_data, 32'd0);
    checkOutput("mid_rst_sel", 32'(out_sel), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_hold_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1);
    rst = 1'b0;
    m_valid = 1'b0;
    m_sel   = 2'd0;
    m_ptr   = 0;

    // Randomized traffic with random backpressure and occasional forcing.
    for (int n = 0; n < 2000; n++) begin
      randomStep(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7));
    end
    for (int n = 0; n < 4; n++) begin
      randomStep(4'b0000, 1'b0, 2'd0, 1'b1);
    end
    checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
